// File: rtl/argmax_output_layer.sv
// Sequential argmax over N_CLASS popcount scores: one comparator, one class per cycle.
// Define ARGMAX_SCORE_OUT_EN to add the registered out_score port carrying the winning value.
module argmax_output_layer #(
   parameter int unsigned N_CLASS = 10,
   parameter int unsigned IN_W    = 6,
   parameter int unsigned IDX_W   = 4,
   parameter bit          SIGNED  = 1'b0
) (
   input  logic                    clk,
   input  logic                    xrst,
   input  logic [N_CLASS*IN_W-1:0] in_scores,
   input  logic                    rcv_ack,
   output logic                    rcv_req,
   input  logic                    snd_req,
   output logic                    snd_ack,
   output logic [IDX_W-1:0]        out_idx
`ifdef ARGMAX_SCORE_OUT_EN
   ,
   output logic [IN_W-1:0]         out_score
`endif
);

   typedef enum logic [2:0] {StWait, StRcv, StCalc, StSndWait, StSnd} state_e;

   state_e           state;
   logic [IN_W-1:0]  score_buf [N_CLASS];
   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] best_idx;

   logic [IN_W-1:0]  cur_score;
   logic [IN_W-1:0]  best_score;
   logic             cur_valid;
   logic             cur_greater;
   logic             last_cmp;
   logic [IDX_W-1:0] next_best;

   // Mux the two operands out of the buffer; cnt past the last class (N_CLASS=1) never wins.
   always_comb begin
      cur_score  = '0;
      best_score = '0;
      cur_valid  = 1'b0;
      for (int k = 0; k < N_CLASS; k++) begin
         if (cnt == IDX_W'(k)) begin
            cur_score = score_buf[k];
            cur_valid = 1'b1;
         end
         if (best_idx == IDX_W'(k)) begin
            best_score = score_buf[k];
         end
      end
   end

   always_comb begin
      cur_greater = 1'b0;
      if (cur_valid) begin
         if (SIGNED) begin
            cur_greater = $signed(cur_score) > $signed(best_score);
         end else begin
            cur_greater = cur_score > best_score;
         end
      end
      next_best = cur_greater ? cnt : best_idx;
      last_cmp  = 32'(cnt) >= (N_CLASS - 32'd1);
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state    <= StWait;
         cnt      <= '0;
         best_idx <= '0;
         out_idx  <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
         out_score <= '0;
`endif
         for (int k = 0; k < N_CLASS; k++) begin
            score_buf[k] <= '0;
         end
      end else begin
         unique case (state)
            StWait: begin
               if (rcv_ack) begin
                  for (int k = 0; k < N_CLASS; k++) begin
                     score_buf[k] <= in_scores[k*IN_W +: IN_W];
                  end
                  state <= StRcv;
               end
            end
            StRcv: begin
               if (!rcv_ack) begin
                  best_idx <= '0;
                  cnt      <= IDX_W'(1);
                  state    <= StCalc;
               end
            end
            StCalc: begin
               best_idx <= next_best;
               cnt      <= cnt + IDX_W'(1);
               if (last_cmp) begin
                  out_idx <= next_best;
`ifdef ARGMAX_SCORE_OUT_EN
                  out_score <= cur_greater ? cur_score : best_score;
`endif
                  state   <= StSndWait;
               end
            end
            StSndWait: begin
               if (snd_req) begin
                  state <= StSnd;
               end
            end
            StSnd: begin
               if (!snd_req) begin
                  state <= StWait;
               end
            end
            default: state <= StWait;
         endcase
      end
   end

   assign rcv_req = (state == StWait);
   assign snd_ack = (state == StSnd);

endmodule

// File: tb/tb_argmax_output_layer.sv
// Self-checking bench: four argmax instances (unsigned/signed 10 classes, 1 class, 16 classes)
// run in lockstep; results are checked against constant tables and a plain-arithmetic model.
module tb_argmax_output_layer;

   logic        clk = 1'b0;
   logic        xrst = 1'b0;
   logic        rcv_ack = 1'b0;
   logic        snd_req = 1'b0;
   logic [59:0] sc0 = '0;
   logic [5:0]  sc1 = '0;
   logic [95:0] sc16 = '0;

   logic        rcv_req0, rcv_reqs, rcv_req1, rcv_req16;
   logic        snd_ack0, snd_acks, snd_ack1, snd_ack16;
   logic [3:0]  out_idx0, out_idxs, out_idx16;
   logic [0:0]  out_idx1;
`ifdef ARGMAX_SCORE_OUT_EN
   logic [5:0]  out_score0, out_scores, out_score1, out_score16;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   argmax_output_layer #(.N_CLASS(10), .IN_W(6), .IDX_W(4), .SIGNED(1'b0)) dut0 (
      .clk(clk), .xrst(xrst), .in_scores(sc0), .rcv_ack(rcv_ack), .rcv_req(rcv_req0),
      .snd_req(snd_req), .snd_ack(snd_ack0), .out_idx(out_idx0)
`ifdef ARGMAX_SCORE_OUT_EN
      , .out_score(out_score0)
`endif
   );

   argmax_output_layer #(.N_CLASS(10), .IN_W(6), .IDX_W(4), .SIGNED(1'b1)) dut_s (
      .clk(clk), .xrst(xrst), .in_scores(sc0), .rcv_ack(rcv_ack), .rcv_req(rcv_reqs),
      .snd_req(snd_req), .snd_ack(snd_acks), .out_idx(out_idxs)
`ifdef ARGMAX_SCORE_OUT_EN
      , .out_score(out_scores)
`endif
   );

   argmax_output_layer #(.N_CLASS(1), .IN_W(6), .IDX_W(1), .SIGNED(1'b0)) dut1 (
      .clk(clk), .xrst(xrst), .in_scores(sc1), .rcv_ack(rcv_ack), .rcv_req(rcv_req1),
      .snd_req(snd_req), .snd_ack(snd_ack1), .out_idx(out_idx1)
`ifdef ARGMAX_SCORE_OUT_EN
      , .out_score(out_score1)
`endif
   );

   argmax_output_layer #(.N_CLASS(16), .IN_W(6), .IDX_W(4), .SIGNED(1'b0)) dut16 (
      .clk(clk), .xrst(xrst), .in_scores(sc16), .rcv_ack(rcv_ack), .rcv_req(rcv_req16),
      .snd_req(snd_req), .snd_ack(snd_ack16), .out_idx(out_idx16)
`ifdef ARGMAX_SCORE_OUT_EN
      , .out_score(out_score16)
`endif
   );

   typedef struct {
      logic [59:0] scores;
      int          exp_u;
      int          exp_s;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int score_val(input logic [95:0] flat, input int k, input bit sgn);
      logic [5:0] r;
      r = flat[k*6 +: 6];
      return (sgn && r[5]) ? int'(r) - 64 : int'(r);
   endfunction

   function automatic int model_idx(input logic [95:0] flat, input int n, input bit sgn);
      int best = 0;
      for (int k = 1; k < n; k++) begin
         if (score_val(flat, k, sgn) > score_val(flat, best, sgn)) best = k;
      end
      return best;
   endfunction

   function automatic logic [95:0] rand_scores(input int n, input int maxv);
      logic [95:0] v = '0;
      for (int k = 0; k < n; k++) v[k*6 +: 6] = 6'($urandom_range(0, maxv));
      return v;
   endfunction

   // One full transaction; hold = cycles rcv_ack stays high, sdelay = cycles snd_req is late.
   task automatic run_txn(input int hold, input int sdelay);
      int          e0, es, e16, edges, lat;
      logic [95:0] f0, f1, f16;
      bit          all_ack, all_req, bad;
      f0  = 96'(sc0);
      f1  = 96'(sc1);
      f16 = sc16;
      e0  = model_idx(f0, 10, 1'b0);
      es  = model_idx(f0, 10, 1'b1);
      e16 = model_idx(f16, 16, 1'b0);
      @(negedge clk);
      rcv_ack = 1'b1;
      snd_req = (sdelay == 0);
      @(posedge clk);
      edges = 1;
      lat   = 0;
      #1;
      sc0  = 60'(rand_scores(10, 63));
      sc1  = 6'($urandom);
      sc16 = rand_scores(16, 63);
      for (int i = 1; i < hold; i++) begin
         @(posedge clk);
         edges++;
      end
      #1;
      rcv_ack = 1'b0;
      if (sdelay > 0) begin
         repeat (20) @(posedge clk);
         #1;
         bad = 1'b0;
         for (int i = 0; i < sdelay; i++) begin
            @(posedge clk);
            #1;
            if (snd_ack0 || snd_ack16 || out_idx0 != 4'(e0)) bad = 1'b1;
         end
         chk("snd_wait_hold", int'(bad), 0);
         snd_req = 1'b1;
      end
      all_ack = 1'b0;
      for (int i = 0; i < 200 && !all_ack; i++) begin
         @(posedge clk);
         edges++;
         #1;
         if (snd_ack0 && lat == 0) lat = edges;
         all_ack = snd_ack0 && snd_acks && snd_ack1 && snd_ack16;
      end
      chk("snd_ack_all", int'(all_ack), 1);
      if (hold == 1 && sdelay == 0) chk("latency", lat, 12);
      chk("idx_u10", int'(out_idx0), e0);
      chk("idx_s10", int'(out_idxs), es);
      chk("idx_n1", int'(out_idx1), 0);
      chk("idx_n16", int'(out_idx16), e16);
`ifdef ARGMAX_SCORE_OUT_EN
      chk("score_u10", int'(out_score0), int'(f0[e0*6 +: 6]));
      chk("score_s10", int'(out_scores), int'(f0[es*6 +: 6]));
      chk("score_n1", int'(out_score1), int'(f1[5:0]));
      chk("score_n16", int'(out_score16), int'(f16[e16*6 +: 6]));
`endif
      @(negedge clk);
      snd_req = 1'b0;
      all_req = 1'b0;
      for (int i = 0; i < 10 && !all_req; i++) begin
         @(posedge clk);
         #1;
         all_req = rcv_req0 && rcv_reqs && rcv_req1 && rcv_req16 &&
                   !snd_ack0 && !snd_acks && !snd_ack1 && !snd_ack16;
      end
      chk("back_to_wait", int'(all_req), 1);
   endtask

   initial begin
      tbl[0] = '{scores: {6'd2, 6'd39, 6'd9, 6'd0, 6'd1, 6'd40, 6'd5, 6'd12, 6'd7, 6'd3},
                 exp_u: 4, exp_s: 2};
      tbl[1] = '{scores: {10{6'd17}}, exp_u: 0, exp_s: 0};
      tbl[2] = '{scores: {6'd63, 6'd0, 6'd63, {7{6'd0}}}, exp_u: 7, exp_s: 0};
      tbl[3] = '{scores: {6'd63, 6'd63, 6'd63, 6'd63, 6'd32, 6'd63, 6'd63, 6'd0, 6'd63, 6'd63},
                 exp_u: 0, exp_s: 2};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_rcv_req", int'(rcv_req0), 1);
      chk("rst_snd_ack", int'(snd_ack0), 0);
      chk("rst_idx", int'(out_idx0), 0);
      @(negedge clk);
      xrst = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_rcv_req", int'(rcv_req0 && rcv_req16 && rcv_req1), 1);

      for (int i = 0; i < 4; i++) begin
         sc0  = tbl[i].scores;
         sc1  = 6'($urandom);
         sc16 = rand_scores(16, 63);
         run_txn(1, 0);
         chk($sformatf("tbl%0d_u", i), int'(out_idx0), tbl[i].exp_u);
         chk($sformatf("tbl%0d_s", i), int'(out_idxs), tbl[i].exp_s);
      end

      // Long rcv_ack with scores changing in RCV, then a late snd_req.
      sc0 = tbl[0].scores;
      run_txn(5, 10);
      chk("hs_captured_idx", int'(out_idx0), 4);

      // Winner in the last of 16 classes.
      sc16 = rand_scores(16, 62);
      sc16[90 +: 6] = 6'd63;
      run_txn(1, 0);
      chk("n16_last", int'(out_idx16), 15);

      // Reset in the middle of a scan (cnt=4 after the third CALC edge).
      sc0 = tbl[0].scores;
      run_txn(1, 0);
      @(negedge clk);
      rcv_ack = 1'b1;
      snd_req = 1'b1;
      sc0 = tbl[2].scores;
      @(posedge clk);
      #1;
      rcv_ack = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      xrst = 1'b0;
      #1;
      chk("midrst_idx", int'(out_idx0), 0);
      chk("midrst_rcv_req", int'(rcv_req0), 1);
      chk("midrst_snd_ack", int'(snd_ack0), 0);
`ifdef ARGMAX_SCORE_OUT_EN
      chk("midrst_score", int'(out_score0), 0);
`endif
      @(negedge clk);
      snd_req = 1'b0;
      xrst = 1'b1;
      sc0 = tbl[2].scores;
      run_txn(1, 0);
      chk("after_rst_idx", int'(out_idx0), 7);

      for (int t = 0; t < 24; t++) begin
         int mx;
         mx   = (t % 3 == 0) ? 3 : 63;
         sc0  = 60'(rand_scores(10, mx));
         sc1  = 6'($urandom);
         sc16 = rand_scores(16, mx);
         run_txn(int'($urandom_range(1, 3)), (t % 5 == 4) ? 4 : 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
